// File: rtl/data_mem_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem_if : LSQ <-> data memory request/ack bundle (rev 1.0)   |
// +------------------------------------------------------------------+
interface data_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic [31:0] mem_read_val;
  logic        mem_err;
  logic        mem_busy;
  logic        req_dropped;

  modport master (
    output mem_req, mem_we, mem_addr, mem_data,
    input  mem_ack, mem_read_val, mem_err, mem_busy, req_dropped
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_data,
    output mem_ack, mem_read_val, mem_err, mem_busy, req_dropped
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem_responder : fixed-latency word RAM responder (rev 1.0)  |
// +------------------------------------------------------------------+
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8,
  parameter int LATENCY     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  lsq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          cap_we;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_data;
  logic          ack;
  logic          err;
  logic          busy;
  logic          dropped;
  logic [31:0]   read_val;

  logic [31:0]   ram [DEPTH_WORDS];

  logic              c_we;
  logic [31:0]       c_addr;
  logic [31:0]       c_data;
  logic [ADDR_W-1:0] c_idx;
  logic              c_err;
  logic              enter_ack;

  // With LATENCY==1 the commit edge is also the capture edge, so the bus feeds the RAM directly.
  assign c_we   = SINGLE ? lsq.mem_we   : cap_we;
  assign c_addr = SINGLE ? lsq.mem_addr : cap_addr;
  assign c_data = SINGLE ? lsq.mem_data : cap_data;
  assign c_idx  = c_addr[ADDR_W+1:2];
  assign c_err  = (c_addr[1:0] != 2'b00) || (c_addr[31:ADDR_W+2] != '0);

  assign enter_ack = rst_n &&
                     ((state == S_IDLE && lsq.mem_req && SINGLE) ||
                      (state == S_WAIT && cnt == 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      cap_we   <= 1'b0;
      cap_addr <= 32'd0;
      cap_data <= 32'd0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      dropped  <= 1'b0;
      read_val <= 32'd0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (lsq.mem_req && state != S_IDLE)
        dropped <= 1'b1;
      if (enter_ack) begin
        ack      <= 1'b1;
        err      <= c_err;
        read_val <= (c_we || c_err) ? 32'd0 : ram[c_idx];
      end
      case (state)
        S_IDLE: begin
          if (lsq.mem_req) begin
            cap_we   <= lsq.mem_we;
            cap_addr <= lsq.mem_addr;
            cap_data <= lsq.mem_data;
            cnt      <= CNT_INIT;
            state    <= SINGLE ? S_ACK : S_WAIT;
            busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= S_ACK;
        end
        S_ACK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM has no reset; aborted requests never reach enter_ack, so nothing is written.
  always_ff @(posedge clk) begin
    if (enter_ack && c_we && !c_err)
      ram[c_idx] <= c_data;
  end

  assign lsq.mem_ack      = ack;
  assign lsq.mem_read_val = read_val;
  assign lsq.mem_err      = err;
  assign lsq.mem_busy     = busy;
  assign lsq.req_dropped  = dropped;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_data_mem_responder : directed bench, LATENCY 2 and 1 (rev 1.0)|
// +------------------------------------------------------------------+
module tb_data_mem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_if bus2 ();
  data_mem_if bus1 ();

  data_mem_responder #(.DEPTH_WORDS(256), .ADDR_W(8), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .lsq(bus2)
  );
  data_mem_responder #(.DEPTH_WORDS(256), .ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .lsq(bus1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      bus1.mem_req = req; bus1.mem_we = we; bus1.mem_addr = addr; bus1.mem_data = data;
    end else begin
      bus2.mem_req = req; bus2.mem_we = we; bus2.mem_addr = addr; bus2.mem_data = data;
    end
  endtask

  task automatic sample(input bit sel, output logic ack, output logic [31:0] rv,
                        output logic err, output logic busy, output logic drp);
    if (sel) begin
      ack = bus1.mem_ack; rv = bus1.mem_read_val; err = bus1.mem_err;
      busy = bus1.mem_busy; drp = bus1.req_dropped;
    end else begin
      ack = bus2.mem_ack; rv = bus2.mem_read_val; err = bus2.mem_err;
      busy = bus2.mem_busy; drp = bus2.req_dropped;
    end
  endtask

  // Called at a negedge; the request is sampled at the following posedge.
  task automatic op(input bit sel, input string tag, input logic we,
                    input logic [31:0] addr, input logic [31:0] data,
                    input int exp_lat, input logic [31:0] exp_rv, input logic exp_err);
    logic ack, err, busy, drp;
    logic [31:0] rv;
    int n;
    drive(sel, 1'b1, we, addr, data);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    n = 1;
    sample(sel, ack, rv, err, busy, drp);
    check_vec({tag, ".busy"}, 32'(busy), 32'd1);
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
      sample(sel, ack, rv, err, busy, drp);
    end
    check_vec({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check_vec({tag, ".rv"}, rv, exp_rv);
    check_vec({tag, ".err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    sample(sel, ack, rv, err, busy, drp);
    check_vec({tag, ".ackpulse"}, 32'(ack), 32'd0);
    check_vec({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic ack, err, busy, drp;
    logic [31:0] rv;
    int acks;

    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s[0], ack, rv, err, busy, drp);
      check_vec("rst.ack", 32'(ack), 32'd0);
      check_vec("rst.rv", rv, 32'd0);
      check_vec("rst.err", 32'(err), 32'd0);
      check_vec("rst.busy", 32'(busy), 32'd0);
      check_vec("rst.drop", 32'(drp), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Known contents for later checks
    op(1'b0, "pre3fc", 1'b1, 32'h3FC, 32'h1234_5678, 2, 32'd0, 1'b0);
    op(1'b0, "pre20",  1'b1, 32'h20,  32'h0,         2, 32'd0, 1'b0);

    // 1: store then load, LAT=2
    op(1'b0, "t1.st", 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 32'd0,         1'b0);
    op(1'b0, "t1.ld", 1'b0, 32'h10, 32'h0,         2, 32'hDEAD_BEEF, 1'b0);

    // 2: second request while busy is dropped
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1);
    sample(1'b0, ack, rv, err, busy, drp);
    check_vec("t2.busy", 32'(busy), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      sample(1'b0, ack, rv, err, busy, drp);
      if (ack) acks++;
      @(negedge clk);
    end
    check_vec("t2.acks", 32'(acks), 32'd1);
    sample(1'b0, ack, rv, err, busy, drp);
    check_vec("t2.drop", 32'(drp), 32'd1);
    op(1'b0, "t2.ld", 1'b0, 32'h20, 32'h0, 2, 32'h0, 1'b0);

    // 3: misaligned store, no RAM side effect
    op(1'b0, "t3.st", 1'b1, 32'h13, 32'hFFFF_FFFF, 2, 32'd0,         1'b1);
    op(1'b0, "t3.ld", 1'b0, 32'h10, 32'h0,         2, 32'hDEAD_BEEF, 1'b0);

    // 4: out-of-range load
    op(1'b0, "t4.ld", 1'b0, 32'h400, 32'h0, 2, 32'd0, 1'b1);

    // 5: reset aborts pending store
    drive(1'b0, 1'b1, 1'b1, 32'h3FC, 32'hA5A5_A5A5);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    sample(1'b0, ack, rv, err, busy, drp);
    check_vec("t5.busy", 32'(busy), 32'd0);
    check_vec("t5.ack", 32'(ack), 32'd0);
    check_vec("t5.drop", 32'(drp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample(1'b0, ack, rv, err, busy, drp);
      if (ack) acks++;
    end
    check_vec("t5.noack", 32'(acks), 32'd0);
    op(1'b0, "t5.ld", 1'b0, 32'h3FC, 32'h0, 2, 32'h1234_5678, 1'b0);

    // 6: LAT=1, requests two cycles apart
    op(1'b1, "t6.st", 1'b1, 32'h3FC, 32'hA5A5_A5A5, 1, 32'd0,         1'b0);
    op(1'b1, "t6.ld", 1'b0, 32'h3FC, 32'h0,         1, 32'hA5A5_A5A5, 1'b0);
    sample(1'b1, ack, rv, err, busy, drp);
    check_vec("t6.drop", 32'(drp), 32'd0);
    check_vec("t6.hold", rv, 32'hA5A5_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
